alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational 64-bit ALU between NREQ requesters (e.g. issue port, address-gen).
//  Round-robin arbitration of valid/ready requests; drives ALU a/b/control, captures result in a
//  one-entry registered response buffer tagged with the winning requester. Sits between issue
//  logic and the ALU; one operation accepted per cycle, result returned one cycle later.
// PARAMETERS
//  NREQ  2   number of requesters (2..8)
//  XLEN  64  operand/result width (matches ALU)
//  IDW   1   width of requester id = max(1,$clog2(NREQ))
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  req_valid    in   NREQ       per-requester operation valid
//  req_ready    out  NREQ       per-requester accept (one-hot or zero)
//  req_a        in   NREQ*XLEN  operand a, requester i at [i*XLEN +: XLEN]
//  req_b        in   NREQ*XLEN  operand b, same packing
//  req_ctrl     in   NREQ*4     ALU control code, requester i at [i*4 +: 4]
//  resp_valid   out  NREQ       one-hot: result buffered for requester i
//  resp_ready   in   NREQ       per-requester result consume
//  resp_out     out  XLEN       buffered ALU result
//  resp_zero    out  1          buffered ALU zero flag
//  resp_err     out  1          1 = control code was unsupported (ALU valid low)
//  resp_id      out  IDW        id of requester owning the buffer
//  alu_a/alu_b  out  XLEN       ALU operands (combinational from winner)
//  alu_control  out  4          ALU control (combinational from winner)
//  alu_out      in   XLEN       ALU result
//  alu_flagzero in   1          ALU zero flag
//  alu_valid    in   1          ALU op-supported flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): resp_valid=0, resp_out=0, resp_zero=0, resp_err=0, resp_id=0,
//    rr pointer=0; req_ready=0 while in reset. In-flight result is discarded, never returned.
//  - free = ~|resp_valid | (resp_valid[resp_id] & resp_ready[resp_id]) (drain+accept same cycle OK).
//  - Winner: first i with req_valid[i] searching ptr, ptr+1, ... NREQ-1, 0 (mod NREQ).
//  - req_ready[winner]=free; all others 0. Fire = req_valid[w] & req_ready[w].
//  - ALU ports always driven from winner; if no valid request, from requester ptr (don't-care).
//  - On fire: resp_out<=alu_out, resp_zero<=alu_flagzero, resp_err<=~alu_valid, resp_id<=w,
//    resp_valid<=one-hot(w); ptr<=(w+1) mod NREQ (wrap at NREQ-1 -> 0).
//  - No fire but drained: resp_valid<=0; data fields hold. No fire, no drain: all hold; ptr holds.
//  - Latency: request accepted cycle N -> resp_valid at cycle N+1. Throughput 1 op/cycle if
//    resp_ready held high.
//  - Back-pressure: while buffer full and not drained, req_ready=0 for all; ptr frozen, so
//    the pending winner keeps priority.
//  - Unsupported ctrl: still accepted and returned with resp_err=1, resp_out=0 (ALU value).
//  - req_ready is combinational from req_valid/resp_ready; no comb path req_valid->resp_*.
//  - Requester must hold a/b/ctrl stable while valid and not ready.
// TESTING
//  1 Reset: rst_n=0 mid-operation with resp_valid=01 -> all outputs 0 asynchronously, ptr=0.
//  2 Single op: req0 a=5 b=3 ctrl=0000, resp_ready=1 -> next cycle resp_valid=01, resp_out=8,
//    resp_zero=0, resp_err=0, resp_id=0.
//  3 Contention: both valid every cycle, resp_ready=11 -> grants alternate 0,1,0,1; one result/cycle.
//  4 Back-pressure: resp_ready=00 after first result -> req_ready=00, buffer holds value; raise
//    resp_ready[owner] -> same-cycle accept of next winner, back-to-back resp_valid.
//  5 Zero/error: req1 a=7 b=7 ctrl=1000 -> resp_out=0, resp_zero=1; ctrl=1111 -> resp_err=1.
//  6 Wrap: NREQ=3, only req2 then req0 valid -> ptr 0->0(w=2)->ptr=0 -> req0 wins; ptr wraps to 0 after w=2.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a one-entry registered response buffer tagged by the winning requester.
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 64,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*4-1:0]    req_ctrl,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_out,
    output logic                 resp_zero,
    output logic                 resp_err,
    output logic [IDW-1:0]       resp_id,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [3:0]           alu_control,
    input  logic [XLEN-1:0]      alu_out,
    input  logic                 alu_flagzero,
    input  logic                 alu_valid
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic [NREQ-1:0] win_oh;
    logic            drain;
    logic            free;
    logic            fire;

    logic [XLEN-1:0] a_arr [NREQ];
    logic [XLEN-1:0] b_arr [NREQ];
    logic [3:0]      c_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*XLEN +: XLEN];
        assign b_arr[i] = req_b[i*XLEN +: XLEN];
        assign c_arr[i] = req_ctrl[i*4 +: 4];
    end

    // Search ptr, ptr+1, ... wrapping; with no valid request the winner stays at ptr.
    always_comb begin
        logic           found;
        logic [IDW-1:0] cand;
        int             idx;
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(ptr) + k) % NREQ;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign drain = resp_valid[resp_id] & resp_ready[resp_id];
    assign free  = ~(|resp_valid) | drain;

    always_comb begin
        req_ready      = '0;
        req_ready[win] = free & rst_n;
        win_oh         = '0;
        win_oh[win]    = 1'b1;
    end

    assign fire        = req_valid[win] & req_ready[win];
    assign alu_a       = a_arr[win];
    assign alu_b       = b_arr[win];
    assign alu_control = c_arr[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_out   <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
            resp_id    <= '0;
            ptr        <= '0;
        end else if (fire) begin
            resp_valid <= win_oh;
            resp_out   <= alu_out;
            resp_zero  <= alu_flagzero;
            resp_err   <= ~alu_valid;
            resp_id    <= win;
            ptr        <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
        end else if (drain) begin
            resp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a 2-requester instance for the main
// sequence and a 3-requester instance for pointer wrap.
module tb_alu_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [65:0] alu_m(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] c);
        logic [63:0] r;
        logic        v;
        v = 1'b1;
        case (c)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            default: begin r = '0; v = 1'b0; end
        endcase
        return {v, (r == 64'd0), r};
    endfunction

    // 2-requester instance
    logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_ctrl;
    logic [63:0]  resp_out, alu_a, alu_b, alu_out;
    logic         resp_zero, resp_err, alu_flagzero, alu_valid;
    logic [0:0]   resp_id;
    logic [3:0]   alu_control;

    assign {alu_valid, alu_flagzero, alu_out} = alu_m(alu_a, alu_b, alu_control);

    alu_rr_arbiter #(.NREQ(2), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_err(resp_err), .resp_id(resp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_flagzero(alu_flagzero), .alu_valid(alu_valid)
    );

    // 3-requester instance
    logic [2:0]   req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [191:0] req_a3, req_b3;
    logic [11:0]  req_ctrl3;
    logic [63:0]  resp_out3, alu_a3, alu_b3, alu_out3;
    logic         resp_zero3, resp_err3, alu_flagzero3, alu_valid3;
    logic [1:0]   resp_id3;
    logic [3:0]   alu_control3;

    assign {alu_valid3, alu_flagzero3, alu_out3} = alu_m(alu_a3, alu_b3, alu_control3);

    alu_rr_arbiter #(.NREQ(3), .XLEN(64)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_ctrl(req_ctrl3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_out(resp_out3), .resp_zero(resp_zero3), .resp_err(resp_err3), .resp_id(resp_id3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_control(alu_control3),
        .alu_out(alu_out3), .alu_flagzero(alu_flagzero3), .alu_valid(alu_valid3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b01; resp_ready = 2'b11;
        req_a = '0; req_b = '0; req_ctrl = '0;
        req_valid3 = '0; resp_ready3 = 3'b111;
        req_a3 = '0; req_b3 = '0; req_ctrl3 = '0;
        tick();
        tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_out", resp_out, 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        // single op: 5 + 3
        req_a[63:0] = 64'd5; req_b[63:0] = 64'd3; req_ctrl[3:0] = 4'b0000;
        req_valid = 2'b01;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        chk("single_alu_a", alu_a, 64'd5);
        tick();
        req_valid = 2'b00;
        chk("single_valid", 64'(resp_valid), 64'h1);
        chk("single_out", resp_out, 64'd8);
        chk("single_zero", 64'(resp_zero), 64'd0);
        chk("single_err", 64'(resp_err), 64'd0);
        chk("single_id", 64'(resp_id), 64'd0);

        // contention: ptr=1 now; req0 = 1+2, req1 = 10-4
        req_a[63:0] = 64'd1;  req_b[63:0] = 64'd2;  req_ctrl[3:0] = 4'b0000;
        req_a[127:64] = 64'd10; req_b[127:64] = 64'd4; req_ctrl[7:4] = 4'b1000;
        req_valid = 2'b11;
        #1;
        chk("cont_ready0", 64'(req_ready), 64'h2);
        tick();
        chk("cont_valid1", 64'(resp_valid), 64'h2);
        chk("cont_out1", resp_out, 64'd6);
        chk("cont_ready1", 64'(req_ready), 64'h1);
        tick();
        chk("cont_valid2", 64'(resp_valid), 64'h1);
        chk("cont_out2", resp_out, 64'd3);
        chk("cont_ready2", 64'(req_ready), 64'h2);
        tick();
        chk("cont_valid3", 64'(resp_valid), 64'h2);
        chk("cont_id3", 64'(resp_id), 64'd1);

        // back-pressure with buffer owned by requester 1
        resp_ready = 2'b00;
        #1;
        chk("bp_ready", 64'(req_ready), 64'h0);
        tick();
        chk("bp_hold_valid", 64'(resp_valid), 64'h2);
        chk("bp_hold_out", resp_out, 64'd6);
        chk("bp_hold_ready", 64'(req_ready), 64'h0);
        resp_ready = 2'b10;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'h1);
        tick();
        chk("bp_b2b_valid", 64'(resp_valid), 64'h1);
        chk("bp_b2b_out", resp_out, 64'd3);
        req_valid = 2'b00; resp_ready = 2'b01;
        tick();
        chk("drain_valid", 64'(resp_valid), 64'h0);
        chk("drain_out_hold", resp_out, 64'd3);

        // zero flag then unsupported control (ptr=1)
        resp_ready = 2'b11;
        req_a[127:64] = 64'd7; req_b[127:64] = 64'd7; req_ctrl[7:4] = 4'b1000;
        req_valid = 2'b10;
        #1;
        chk("zero_ready", 64'(req_ready), 64'h2);
        tick();
        chk("zero_out", resp_out, 64'd0);
        chk("zero_flag", 64'(resp_zero), 64'd1);
        chk("zero_err", 64'(resp_err), 64'd0);
        chk("zero_id", 64'(resp_id), 64'd1);
        req_ctrl[7:4] = 4'b1111;
        #1;
        chk("err_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        chk("err_flag", 64'(resp_err), 64'd1);
        chk("err_out", resp_out, 64'd0);
        chk("err_valid", 64'(resp_valid), 64'h2);

        // async reset with requester 0 owning the buffer (ptr=0 -> w=0 -> ptr=1)
        req_a[63:0] = 64'd2; req_b[63:0] = 64'd2; req_ctrl[3:0] = 4'b0000;
        req_valid = 2'b01;
        tick();
        resp_ready = 2'b00;
        chk("pre_rst_valid", 64'(resp_valid), 64'h1);
        chk("pre_rst_out", resp_out, 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(resp_valid), 64'h0);
        chk("arst_out", resp_out, 64'd0);
        chk("arst_id", 64'(resp_id), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        chk("arst_ptr0", 64'(req_ready), 64'h1);
        tick();
        chk("arst_no_stale", resp_out, 64'd4);
        req_valid = 2'b00;

        // wrap on the 3-requester instance: req2 = 20+5, then req0 = 1+1
        req_a3[191:128] = 64'd20; req_b3[191:128] = 64'd5; req_ctrl3[11:8] = 4'b0000;
        req_a3[63:0] = 64'd1; req_b3[63:0] = 64'd1; req_ctrl3[3:0] = 4'b0000;
        req_valid3 = 3'b100;
        #1;
        chk("wrap_ready_w2", 64'(req_ready3), 64'h4);
        tick();
        chk("wrap_valid_w2", 64'(resp_valid3), 64'h4);
        chk("wrap_out_w2", resp_out3, 64'd25);
        chk("wrap_id_w2", 64'(resp_id3), 64'd2);
        req_valid3 = 3'b101;
        #1;
        chk("wrap_ready_w0", 64'(req_ready3), 64'h1);
        tick();
        chk("wrap_valid_w0", 64'(resp_valid3), 64'h1);
        chk("wrap_out_w0", resp_out3, 64'd2);
        chk("wrap_id_w0", 64'(resp_id3), 64'd0);
        chk("wrap_ready_next", 64'(req_ready3), 64'h4);
        req_valid3 = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
